ifu_fetch: RTL

//  Instruction fetch unit; feeds the decoder (dec) with instruction/address pairs.

---
 rtl/ifu_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues imem requests under credit limits, buffers returns in order for dec.
// Optional IFU_BYPASS_EN forwards an unsquashed return straight to dec when the buffer is empty.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_from_exe,
    input  logic [31:0] flush_addr_exe,
    input  logic        flush_from_dec,
    input  logic [31:0] flush_addr_dec,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_ifu_2_dec_o,
    output logic [31:0] instr_addr_ifu_2_dec_o,
    output logic        instr_valid_o,
    input  logic        dec_ready_i
);

    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] squash_q, squash_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [31:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0] tag_q       [FIFO_DEPTH];

    logic        flush, issue, ret_sq, ret_ok, push, pop, head_valid, byp;
    logic [31:0] target;

    // Issue credit, return classification and dec-side presentation
    always_comb begin
        flush      = flush_from_exe | flush_from_dec;
        target     = (flush_from_exe ? flush_addr_exe : flush_addr_dec) & ~32'h3;
        imem_req_o = !rst && ((cnt_q + inflight_q) < CW'(FIFO_DEPTH))
                          && ((inflight_q + squash_q) < CW'(MAX_OUTSTANDING));
        imem_addr_o = pc_q;
        issue      = imem_req_o & imem_gnt_i;
        ret_sq     = imem_rvalid_i & (squash_q != '0);
        ret_ok     = imem_rvalid_i & (squash_q == '0) & (inflight_q != '0);
        head_valid = (cnt_q != '0);
`ifdef IFU_BYPASS_EN
        byp        = ret_ok & !head_valid;
`else
        byp        = 1'b0;
`endif
        pop        = head_valid & dec_ready_i;
        push       = ret_ok & !(byp & dec_ready_i);

        instr_valid_o          = head_valid | byp;
        instr_ifu_2_dec_o      = NOP;
        instr_addr_ifu_2_dec_o = '0;
        if (head_valid) begin
            instr_ifu_2_dec_o      = fifo_data_q[rd_ptr_q];
            instr_addr_ifu_2_dec_o = fifo_addr_q[rd_ptr_q];
        end else if (byp) begin
            instr_ifu_2_dec_o      = imem_rdata_i;
            instr_addr_ifu_2_dec_o = tag_q[tag_rd_q];
        end
    end

    // Next-state for PC, pointers and counters; a flush redirects and turns all in-flight into squash credit
    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        squash_d   = squash_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        if (flush) begin
            pc_d       = target;
            cnt_d      = '0;
            inflight_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            squash_d   = squash_q + inflight_q + CW'(issue) - CW'(ret_sq | ret_ok);
        end else begin
            if (issue) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = tag_wr_q + PW'(1);
            end
            if (ret_ok) tag_rd_d = tag_rd_q + PW'(1);
            if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d      = cnt_q + CW'(push) - CW'(pop);
            inflight_d = inflight_q + CW'(issue) - CW'(ret_ok);
            squash_d   = squash_q - CW'(ret_sq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            inflight_q <= '0;
            squash_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counters
    always_ff @(posedge clk) begin
        if (!flush && push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata_i;
            fifo_addr_q[wr_ptr_q] <= tag_q[tag_rd_q];
        end
        if (!flush && issue) tag_q[tag_wr_q] <= pc_q;
    end

endmodule
